// File: rtl/led_ctrl_pkg.sv
// Shared types and constants for the LED pattern sequencer: modes, FSM states,
// arbitrated commands and per-mode seed patterns.
package led_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_ROTL  = 2'd0,
    MODE_ROTR  = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_PONG  = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_PAUSE = 2'd1,
    ST_LOAD  = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    CMD_NONE   = 3'd0,
    CMD_MODE   = 3'd1,
    CMD_FASTER = 3'd2,
    CMD_SLOWER = 3'd3,
    CMD_PAUSE  = 3'd4
  } cmd_t;

  localparam logic [3:0] SEED_ROTL  = 4'b0001;
  localparam logic [3:0] SEED_ROTR  = 4'b1000;
  localparam logic [3:0] SEED_BLINK = 4'b1111;
  localparam logic [3:0] SEED_PONG  = 4'b0001;
  localparam logic [3:0] LED_RESET  = 4'b0001;

  localparam logic [1:0] SPEED_MAX = 2'd3;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  function automatic logic [3:0] seed_of(input mode_t m);
    logic [3:0] s;
    case (m)
      MODE_ROTL:  s = SEED_ROTL;
      MODE_ROTR:  s = SEED_ROTR;
      MODE_BLINK: s = SEED_BLINK;
      default:    s = SEED_PONG;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/led_pattern_ctrl_if.sv
// Command/status bundle between the key block, the LED sequencer and the LED pins.
// master drives key pulses and observes status; slave is the sequencer.
interface led_pattern_ctrl_if;
  logic [3:0] key_pls;
  logic [3:0] led;
  logic [1:0] mode;
  logic [1:0] speed;
  logic       running;
  logic       step_pls;

  modport master (
    output key_pls,
    input  led, mode, speed, running, step_pls
  );

  modport slave (
    input  key_pls,
    output led, mode, speed, running, step_pls
  );
endinterface

// File: rtl/led_tick_gen.sv
// Programmable step divider: up-counter wrapping at the terminal count (period-1),
// with synchronous clear that also suppresses the tick in its cycle.
module led_tick_gen #(
  parameter int CNT_W = 3
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic [CNT_W-1:0] period_m1,
  input  logic             clr,
  input  logic             en,
  output logic             tick
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tick = en && !clr && (cnt_q == period_m1);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/led_pattern_ctrl.sv
// 4-LED pattern sequencer: key-command arbiter, run/pause/load FSM and pattern register.
// Build option LED_ACTIVE_LOW_EN: when defined the led port is driven inverted (0 = lit).
//
//  state    | meaning
//  ---------+-----------------------------------------------------------
//  ST_RUN   | divider counting, led advances on each tick
//  ST_PAUSE | divider and led frozen, mode/speed keys still accepted
//  ST_LOAD  | one cycle after a mode change: seed led, clear divider
module led_pattern_ctrl
  import led_ctrl_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int STEP_MS     = 200
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  led_pattern_ctrl_if.slave  bus
);

  // TICK_CYC must be >= 8 so that the fastest level (T/8) still spans a cycle.
  localparam int TICK_CYC = CLK_FREQ_HZ / 1000 * STEP_MS;
  localparam int CNT_W    = $clog2(TICK_CYC);

  state_t     state_q, state_d;
  mode_t      mode_q, mode_d;
  logic [1:0] speed_q, speed_d;
  logic       running_q, running_d;
  logic [3:0] led_q, led_d;
  logic       dir_q, dir_d;

  cmd_t             cmd;
  logic             tick_en;
  logic             tick_clr;
  logic             step;
  logic [CNT_W-1:0] period_m1;
  logic [3:0]       pong_nxt;

  assign period_m1 = CNT_W'((TICK_CYC >> speed_q) - 1);

  led_tick_gen #(
    .CNT_W (CNT_W)
  ) u_tick_gen (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .period_m1 (period_m1),
    .clr       (tick_clr),
    .en        (tick_en),
    .tick      (step)
  );

  // Fixed priority run/pause > mode > faster > slower; losers are dropped.
  always_comb begin
    cmd = CMD_NONE;
    if (bus.key_pls[3]) begin
      cmd = CMD_PAUSE;
    end else if (bus.key_pls[0]) begin
      cmd = CMD_MODE;
    end else if (bus.key_pls[1]) begin
      cmd = CMD_FASTER;
    end else if (bus.key_pls[2]) begin
      cmd = CMD_SLOWER;
    end
  end

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    speed_d   = speed_q;
    running_d = running_q;

    case (cmd)
      CMD_PAUSE:  running_d = ~running_q;
      CMD_MODE:   mode_d = mode_t'(mode_q + 2'd1);
      CMD_FASTER: if (speed_q != SPEED_MAX) speed_d = speed_q + 2'd1;
      CMD_SLOWER: if (speed_q != 2'd0) speed_d = speed_q - 2'd1;
      default:    ;
    endcase

    if (cmd == CMD_MODE) begin
      state_d = ST_LOAD;
    end else if (running_d) begin
      state_d = ST_RUN;
    end else begin
      state_d = ST_PAUSE;
    end

    // A pause or mode command freezes the divider in the cycle it is accepted.
    tick_en  = (state_q == ST_RUN) && (cmd != CMD_PAUSE) && (cmd != CMD_MODE);
    tick_clr = (state_q == ST_LOAD) || (speed_d != speed_q);
  end

  always_comb begin
    led_d    = led_q;
    dir_d    = dir_q;
    pong_nxt = (dir_q == DIR_LEFT) ? {led_q[2:0], 1'b0} : {1'b0, led_q[3:1]};

    if (state_q == ST_LOAD) begin
      led_d = seed_of(mode_q);
      dir_d = DIR_LEFT;
    end else if (step) begin
      case (mode_q)
        MODE_ROTL:  led_d = {led_q[2:0], led_q[3]};
        MODE_ROTR:  led_d = {led_q[0], led_q[3:1]};
        MODE_BLINK: led_d = ~led_q;
        default: begin
          led_d = pong_nxt;
          if (pong_nxt == 4'b1000) begin
            dir_d = DIR_RIGHT;
          end else if (pong_nxt == 4'b0001) begin
            dir_d = DIR_LEFT;
          end
        end
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= ST_RUN;
      mode_q    <= MODE_ROTL;
      speed_q   <= 2'd0;
      running_q <= 1'b1;
      led_q     <= LED_RESET;
      dir_q     <= DIR_LEFT;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      speed_q   <= speed_d;
      running_q <= running_d;
      led_q     <= led_d;
      dir_q     <= dir_d;
    end
  end

`ifdef LED_ACTIVE_LOW_EN
  assign bus.led = ~led_q;
`else
  assign bus.led = led_q;
`endif

  assign bus.mode     = mode_q;
  assign bus.speed    = speed_q;
  assign bus.running  = running_q;
  assign bus.step_pls = step;

endmodule
